// File: rtl/tag_mem_responder.sv
// Responder end of the tagged memory request/response interface: queues tagged
// reads, answers them in order after a fixed minimum latency, and flags tag reuse.
module tag_mem_responder #(
   parameter int addr_width  = 64,
   parameter int data_width  = 1024,
   parameter int tag         = 256,
   parameter int tag_width   = $clog2(tag),
   parameter int latency     = 4,
   parameter int depth       = 8,
   parameter int depth_width = $clog2(depth + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_req_v,
   output logic                   i_req_r,
   input  logic [addr_width-1:0]  i_req_ea,
   input  logic [tag_width-1:0]   i_req_tag,
   output logic                   o_rsp_v,
   input  logic                   o_rsp_r,
   output logic [tag_width-1:0]   o_rsp_tag,
   output logic [data_width-1:0]  o_rsp_data,
   output logic [depth_width-1:0] o_cnt,
   output logic                   o_err
);

   localparam int ptr_width = (depth > 1) ? $clog2(depth) : 1;
   localparam int cd_width  = (latency > 1) ? $clog2(latency) : 1;
   localparam int slices    = data_width / addr_width;

   localparam logic [depth_width-1:0] full_cnt = depth_width'(depth);
   localparam logic [ptr_width-1:0]   last_ptr = ptr_width'(depth - 1);
   localparam logic [cd_width-1:0]    cd_init  = cd_width'(latency - 1);

   logic [ptr_width-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ptr_width-1:0]   rd_ptr_q, rd_ptr_d;
   logic [depth_width-1:0] cnt_q, cnt_d;
   logic [cd_width-1:0]    cd_q [depth];
   logic [cd_width-1:0]    cd_d [depth];
   logic [tag-1:0]         inflight_q, inflight_d;
   logic                   err_q, err_d;

   logic [addr_width-1:0]  ea_q  [depth];
   logic [tag_width-1:0]   tag_q [depth];

   logic full;
   logic empty;
   logic accept;
   logic pop;
   logic dup;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high. Ready/valid depend only on registered state and reset, never on
   // the partner's valid/ready.
   assign full    = (cnt_q == full_cnt);
   assign empty   = (cnt_q == '0);
   assign i_req_r = reset & ~full;
   assign o_rsp_v = reset & ~empty & (cd_q[rd_ptr_q] == '0);
   assign accept  = i_req_v & i_req_r;
   assign pop     = o_rsp_v & o_rsp_r;

   assign o_rsp_tag = tag_q[rd_ptr_q];
   assign o_cnt     = cnt_q;
   assign o_err     = err_q;

   always_comb begin
      o_rsp_data = '0;
      for (int k = 0; k < slices; k++) begin
         o_rsp_data[k*addr_width +: addr_width] = ea_q[rd_ptr_q] + addr_width'(k);
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (accept) begin
         wr_ptr_d = (wr_ptr_q == last_ptr) ? '0 : wr_ptr_q + ptr_width'(1);
      end
      rd_ptr_d = rd_ptr_q;
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == last_ptr) ? '0 : rd_ptr_q + ptr_width'(1);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({accept, pop})
         2'b10:   cnt_d = cnt_q + depth_width'(1);
         2'b01:   cnt_d = cnt_q - depth_width'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Idle slots also count down; they are reloaded on accept, so this is harmless.
   always_comb begin
      for (int i = 0; i < depth; i++) begin
         cd_d[i] = (cd_q[i] != '0) ? cd_q[i] - cd_width'(1) : '0;
      end
      if (accept) begin
         cd_d[wr_ptr_q] = cd_init;
      end
   end

   // Clear-then-set ordering lets a tag be retired and reissued in the same cycle.
   always_comb begin
      inflight_d = inflight_q;
      if (pop) begin
         inflight_d[o_rsp_tag] = 1'b0;
      end
      if (accept) begin
         inflight_d[i_req_tag] = 1'b1;
      end
      dup   = accept & inflight_q[i_req_tag] & ~(pop & (o_rsp_tag == i_req_tag));
      err_d = err_q | dup;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         inflight_q <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < depth; i++) begin
            cd_q[i] <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
         for (int i = 0; i < depth; i++) begin
            cd_q[i] <= cd_d[i];
         end
      end
   end

   // Payload storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (accept) begin
         ea_q[wr_ptr_q]  <= i_req_ea;
         tag_q[wr_ptr_q] <= i_req_tag;
      end
   end

endmodule

// File: tb/tb_tag_mem_responder.sv
// Directed bench for tag_mem_responder: a per-cycle vector table for latency and
// same-cycle tag reuse, plus hand sequences for fill/drain, backpressure, duplicates, reset.
module tb_tag_mem_responder;

   localparam int AW  = 64;
   localparam int DW  = 1024;
   localparam int NT  = 256;
   localparam int TW  = 8;
   localparam int LAT = 4;
   localparam int DEP = 8;
   localparam int CW  = 4;
   localparam int NS  = DW / AW;

   logic          clk;
   logic          reset;
   logic          i_req_v;
   logic          i_req_r;
   logic [AW-1:0] i_req_ea;
   logic [TW-1:0] i_req_tag;
   logic          o_rsp_v;
   logic          o_rsp_r;
   logic [TW-1:0] o_rsp_tag;
   logic [DW-1:0] o_rsp_data;
   logic [CW-1:0] o_cnt;
   logic          o_err;

   tag_mem_responder #(
      .addr_width (AW),
      .data_width (DW),
      .tag        (NT),
      .tag_width  (TW),
      .latency    (LAT),
      .depth      (DEP),
      .depth_width(CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .i_req_v   (i_req_v),
      .i_req_r   (i_req_r),
      .i_req_ea  (i_req_ea),
      .i_req_tag (i_req_tag),
      .o_rsp_v   (o_rsp_v),
      .o_rsp_r   (o_rsp_r),
      .o_rsp_tag (o_rsp_tag),
      .o_rsp_data(o_rsp_data),
      .o_cnt     (o_cnt),
      .o_err     (o_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   logic [TW-1:0] exp_tag_q [$];
   logic [AW-1:0] exp_ea_q  [$];

   typedef struct {
      logic          rst_n;
      logic          req_v;
      logic [AW-1:0] ea;
      logic [TW-1:0] tg;
      logic          rsp_r;
      logic          exp_req_r;
      logic          exp_rsp_v;
      logic [TW-1:0] exp_tag;
      logic [AW-1:0] exp_ea;
      logic [CW-1:0] exp_cnt;
      logic          exp_err;
   } vec_t;

   vec_t vecs [16];

   function automatic vec_t mk(input logic rst_n, input logic req_v, input logic [AW-1:0] ea,
                               input logic [TW-1:0] tg, input logic rsp_r, input logic exp_req_r,
                               input logic exp_rsp_v, input logic [TW-1:0] exp_tag,
                               input logic [AW-1:0] exp_ea, input logic [CW-1:0] exp_cnt,
                               input logic exp_err);
      vec_t v;
      v.rst_n = rst_n;  v.req_v = req_v;  v.ea = ea;  v.tg = tg;  v.rsp_r = rsp_r;
      v.exp_req_r = exp_req_r;  v.exp_rsp_v = exp_rsp_v;  v.exp_tag = exp_tag;
      v.exp_ea = exp_ea;  v.exp_cnt = exp_cnt;  v.exp_err = exp_err;
      return v;
   endfunction

   function automatic logic [DW-1:0] make_data(input logic [AW-1:0] ea);
      logic [DW-1:0] d;
      d = '0;
      for (int k = 0; k < NS; k++) begin
         d[k*AW +: AW] = ea + AW'(k);
      end
      return d;
   endfunction

   // scoreboard helpers
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      int bad;
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         bad = 0;
         for (int k = NS - 1; k >= 0; k--) begin
            if (act[k*AW +: AW] !== exp[k*AW +: AW]) bad = k;
         end
         $display("FAIL %s: slice %0d got 0x%0h expected 0x%0h (t=%0t)", name, bad,
                  act[bad*AW +: AW], exp[bad*AW +: AW], $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [TW-1:0] tg, input logic [AW-1:0] ea);
      i_req_v   = 1'b1;
      i_req_tag = tg;
      i_req_ea  = ea;
      #1;
      check("send_req_r", i_req_r, 1'b1);
      exp_tag_q.push_back(tg);
      exp_ea_q.push_back(ea);
      tick();
      i_req_v = 1'b0;
   endtask

   // Drains n expected responses from the queues; with toggle set o_rsp_r alternates 0/1.
   task automatic collect(input string name, input int n, input bit toggle);
      int  got;
      bit  must_hold;
      got       = 0;
      must_hold = 1'b0;
      for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
         o_rsp_r = toggle ? cyc[0] : 1'b1;
         #1;
         if (must_hold) check({name, "_hold_v"}, o_rsp_v, 1'b1);
         if (o_rsp_v) begin
            if (exp_tag_q.size() == 0) begin
               check({name, "_extra_rsp"}, 1'b1, 1'b0);
            end else begin
               check({name, "_tag"}, o_rsp_tag, exp_tag_q[0]);
               check_data({name, "_data"}, o_rsp_data, make_data(exp_ea_q[0]));
               if (o_rsp_r) begin
                  void'(exp_tag_q.pop_front());
                  void'(exp_ea_q.pop_front());
                  got++;
               end
            end
         end
         must_hold = o_rsp_v & ~o_rsp_r;
         tick();
      end
      check({name, "_count"}, got, n);
      o_rsp_r = 1'b0;
   endtask

   initial begin
      int stray;
      reset     = 1'b0;
      i_req_v   = 1'b0;
      i_req_ea  = '0;
      i_req_tag = '0;
      o_rsp_r   = 1'b0;

      // reset state
      tick();
      check("rst_cnt", o_cnt, 0);
      check("rst_err", o_err, 0);
      check("rst_req_r", i_req_r, 0);
      check("rst_rsp_v", o_rsp_v, 0);
      tick();

      // minimum latency (rows 0-5) and same-cycle tag reuse (rows 6-15)
      vecs[0]  = mk(1, 1, 64'h1000, 5, 1,  1, 0, 0, 64'h0,    0, 0);
      vecs[1]  = mk(1, 0, 64'h0,    0, 1,  1, 0, 0, 64'h0,    1, 0);
      vecs[2]  = mk(1, 0, 64'h0,    0, 1,  1, 0, 0, 64'h0,    1, 0);
      vecs[3]  = mk(1, 0, 64'h0,    0, 1,  1, 0, 0, 64'h0,    1, 0);
      vecs[4]  = mk(1, 0, 64'h0,    0, 1,  1, 1, 5, 64'h1000, 1, 0);
      vecs[5]  = mk(1, 0, 64'h0,    0, 1,  1, 0, 0, 64'h0,    0, 0);
      vecs[6]  = mk(1, 1, 64'h2000, 3, 1,  1, 0, 0, 64'h0,    0, 0);
      vecs[7]  = mk(1, 0, 64'h0,    0, 1,  1, 0, 0, 64'h0,    1, 0);
      vecs[8]  = mk(1, 0, 64'h0,    0, 1,  1, 0, 0, 64'h0,    1, 0);
      vecs[9]  = mk(1, 0, 64'h0,    0, 1,  1, 0, 0, 64'h0,    1, 0);
      vecs[10] = mk(1, 1, 64'h3000, 3, 1,  1, 1, 3, 64'h2000, 1, 0);
      vecs[11] = mk(1, 0, 64'h0,    0, 1,  1, 0, 0, 64'h0,    1, 0);
      vecs[12] = mk(1, 0, 64'h0,    0, 1,  1, 0, 0, 64'h0,    1, 0);
      vecs[13] = mk(1, 0, 64'h0,    0, 1,  1, 0, 0, 64'h0,    1, 0);
      vecs[14] = mk(1, 0, 64'h0,    0, 1,  1, 1, 3, 64'h3000, 1, 0);
      vecs[15] = mk(1, 0, 64'h0,    0, 1,  1, 0, 0, 64'h0,    0, 0);

      for (int r = 0; r < 16; r++) begin
         reset     = vecs[r].rst_n;
         i_req_v   = vecs[r].req_v;
         i_req_ea  = vecs[r].ea;
         i_req_tag = vecs[r].tg;
         o_rsp_r   = vecs[r].rsp_r;
         #1;
         check($sformatf("vec%0d_req_r", r), i_req_r, vecs[r].exp_req_r);
         check($sformatf("vec%0d_rsp_v", r), o_rsp_v, vecs[r].exp_rsp_v);
         check($sformatf("vec%0d_cnt", r), o_cnt, vecs[r].exp_cnt);
         check($sformatf("vec%0d_err", r), o_err, vecs[r].exp_err);
         if (vecs[r].exp_rsp_v) begin
            check($sformatf("vec%0d_tag", r), o_rsp_tag, vecs[r].exp_tag);
            check_data($sformatf("vec%0d_data", r), o_rsp_data, make_data(vecs[r].exp_ea));
         end
         tick();
      end
      i_req_v = 1'b0;
      o_rsp_r = 1'b0;

      // fill and drain
      for (int i = 0; i < DEP; i++) begin
         i_req_v   = 1'b1;
         i_req_tag = TW'(i);
         i_req_ea  = 64'h4000 + 64'(i) * 64'h100;
         #1;
         check($sformatf("fill%0d_req_r", i), i_req_r, 1'b1);
         check($sformatf("fill%0d_cnt", i), o_cnt, i);
         tick();
      end
      i_req_tag = 8'd8;
      i_req_ea  = 64'h5000;
      for (int w = 0; w < 4; w++) begin
         #1;
         check("full_req_r", i_req_r, 1'b0);
         check("full_cnt", o_cnt, DEP);
         check("full_rsp_v", o_rsp_v, 1'b1);
         tick();
      end
      o_rsp_r = 1'b1;
      for (int d = 0; d <= DEP; d++) begin
         #1;
         check($sformatf("drain%0d_rsp_v", d), o_rsp_v, 1'b1);
         check($sformatf("drain%0d_tag", d), o_rsp_tag, d);
         check_data($sformatf("drain%0d_data", d), o_rsp_data,
                    make_data((d == DEP) ? 64'h5000 : 64'h4000 + 64'(d) * 64'h100));
         check($sformatf("drain%0d_cnt", d), o_cnt, (d == 0) ? 8 : (d == 1) ? 7 : 9 - d);
         if (d == 0) check("drain_pop_no_ready", i_req_r, 1'b0);
         if (d == 1) check("drain_ready_after_pop", i_req_r, 1'b1);
         tick();
         if (d == 1) i_req_v = 1'b0;
      end
      #1;
      check("drained_cnt", o_cnt, 0);
      check("drained_rsp_v", o_rsp_v, 1'b0);
      tick();
      o_rsp_r = 1'b0;

      // backpressure stability
      for (int i = 0; i < 4; i++) send(TW'(10 + i), 64'h7000 + 64'(i) * 64'h10);
      collect("bp", 4, 1'b1);
      tick();
      tick();
      #1;
      check("bp_no_dup_rsp_v", o_rsp_v, 1'b0);
      check("bp_cnt", o_cnt, 0);
      tick();

      // duplicate tag
      i_req_v   = 1'b1;
      i_req_tag = 8'd7;
      i_req_ea  = 64'h6000;
      #1;
      check("dup_first_err", o_err, 1'b0);
      exp_tag_q.push_back(8'd7);
      exp_ea_q.push_back(64'h6000);
      tick();
      i_req_ea = 64'h6100;
      #1;
      check("dup_second_req_r", i_req_r, 1'b1);
      check("dup_second_err", o_err, 1'b0);
      exp_tag_q.push_back(8'd7);
      exp_ea_q.push_back(64'h6100);
      tick();
      i_req_v = 1'b0;
      #1;
      check("dup_err_set", o_err, 1'b1);
      check("dup_cnt", o_cnt, 2);
      tick();
      collect("dup", 2, 1'b0);
      #1;
      check("dup_err_sticky", o_err, 1'b1);
      tick();

      // reset mid-operation
      send(8'd20, 64'h8000);
      send(8'd21, 64'h8100);
      send(8'd22, 64'h8200);
      tick();
      tick();
      #1;
      check("prerst_rsp_v", o_rsp_v, 1'b1);
      check("prerst_cnt", o_cnt, 3);
      tick();
      reset = 1'b0;
      #1;
      check("inrst_rsp_v", o_rsp_v, 1'b0);
      check("inrst_req_r", i_req_r, 1'b0);
      tick();
      reset = 1'b1;
      exp_tag_q.delete();
      exp_ea_q.delete();
      #1;
      check("postrst_cnt", o_cnt, 0);
      check("postrst_err", o_err, 1'b0);
      check("postrst_req_r", i_req_r, 1'b1);
      check("postrst_rsp_v", o_rsp_v, 1'b0);
      o_rsp_r = 1'b1;
      stray = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         #1;
         if (o_rsp_v) stray++;
      end
      check("postrst_stray_rsp", stray, 0);
      o_rsp_r = 1'b0;

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
